// File: rtl/mure_pkg.sv
// Shared types for the MuRE trace encoder: commit-port entry format and
// instantiation defaults for the commit FIFO.
package mure_pkg;

    localparam int unsigned XLEN              = 64;
    localparam int unsigned NR_COMMIT_PORTS   = 2;
    localparam int unsigned COMMIT_FIFO_DEPTH = 16;

    typedef enum logic [2:0] {
        ItStandard    = 3'd0,
        ItException   = 3'd1,
        ItInterrupt   = 3'd2,
        ItEret        = 3'd3,
        ItNonstdJump  = 3'd4,
        ItUninfJump   = 3'd5,
        ItUninfBranch = 3'd6
    } itype_e;

    typedef struct packed {
        logic            valid;
        itype_e          itype;
        logic            compressed;
        logic [1:0]      priv;
        logic [XLEN-1:0] pc;
    } fifo_entry_s;

    function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/commit_compactor.sv
// Packs the valid commit-port entries into the low slots in ascending port order
// and reports how many there are.
module commit_compactor
    import mure_pkg::*;
#(
    parameter int unsigned NR_PORTS = NR_COMMIT_PORTS,
    localparam int unsigned CntW    = $clog2(NR_PORTS) + 1
) (
    input  fifo_entry_s [NR_PORTS-1:0] entry_i,
    output fifo_entry_s [NR_PORTS-1:0] entry_o,
    output logic [CntW-1:0]            count_o
);

    int unsigned rank [NR_PORTS];
    int unsigned nvalid;

    always_comb begin
        nvalid = 0;
        for (int unsigned k = 0; k < NR_PORTS; k++) begin
            rank[k] = nvalid;
            if (entry_i[k].valid) begin
                nvalid = nvalid + 1;
            end
        end

        // Slot j takes the valid port whose rank (valid ports below it) equals j
        entry_o = '0;
        for (int unsigned j = 0; j < NR_PORTS; j++) begin
            for (int unsigned k = 0; k < NR_PORTS; k++) begin
                if (entry_i[k].valid && (rank[k] == j)) begin
                    entry_o[j] = entry_i[k];
                end
            end
        end
    end

    assign count_o = CntW'(nvalid);

endmodule

// File: rtl/commit_fifo.sv
// Buffers classified commit-port entries: up to NR_PORTS pushes and exactly one
// pop per cycle (whenever non-empty), with sticky overflow on dropped entries.
module commit_fifo
    import mure_pkg::*;
#(
    parameter int unsigned DEPTH    = COMMIT_FIFO_DEPTH,
    parameter int unsigned NR_PORTS = NR_COMMIT_PORTS,
    localparam int unsigned PtrW    = $clog2(DEPTH),
    localparam int unsigned CntW    = PtrW + 1,
    localparam int unsigned PortCntW = $clog2(NR_PORTS) + 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  fifo_entry_s [NR_PORTS-1:0] entry_i,
    input  logic                       flush_i,
    output fifo_entry_s                fifo_entry_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [CntW-1:0]            usage_o,
    output logic                       overflow_o
);

    fifo_entry_s [NR_PORTS-1:0] comp_entries;
    logic [PortCntW-1:0]        comp_cnt;

    commit_compactor #(
        .NR_PORTS (NR_PORTS)
    ) u_compactor (
        .entry_i (entry_i),
        .entry_o (comp_entries),
        .count_o (comp_cnt)
    );

    fifo_entry_s     mem_q [DEPTH];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] usage_q, usage_d;
    logic            overflow_q, overflow_d;

    logic        pop;
    int unsigned free_cnt;
    int unsigned accept_cnt;

    always_comb begin
        pop = (usage_q != '0);
        // A same-cycle pop frees its slot for this cycle's pushes
        free_cnt   = DEPTH - 32'(usage_q) + 32'(pop);
        accept_cnt = min_u(32'(comp_cnt), free_cnt);

        usage_d    = usage_q + CntW'(accept_cnt) - CntW'(pop);
        wptr_d     = wptr_q + PtrW'(accept_cnt);
        rptr_d     = rptr_q + PtrW'(pop);
        overflow_d = overflow_q | (32'(comp_cnt) > free_cnt);

        if (flush_i) begin
            accept_cnt = 0;
            usage_d    = '0;
            wptr_d     = '0;
            rptr_d     = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            usage_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            usage_q    <= usage_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset; slots are only read once usage covers them
    always_ff @(posedge clk_i) begin
        for (int unsigned j = 0; j < NR_PORTS; j++) begin
            if (j < accept_cnt) begin
                mem_q[wptr_q + PtrW'(j)] <= comp_entries[j];
            end
        end
    end

    always_comb begin
        fifo_entry_o = '0;
        if (pop) begin
            fifo_entry_o       = mem_q[rptr_q];
            fifo_entry_o.valid = 1'b1;
        end
    end

    assign empty_o    = (usage_q == '0);
    assign full_o     = (usage_q == CntW'(DEPTH));
    assign usage_o    = usage_q;
    assign overflow_o = overflow_q;

endmodule

// File: doc/commit_fifo.md
Name: commit_fifo

Overview:
- Buffers classified CVA6 commit-port entries (mure_pkg::fifo_entry_s) between the commit-port classifier and the iaddr/iretire/ilastsize FSM.
- Accepts up to NR_PORTS entries per cycle, compacted in port order.
- Presents at most one entry per cycle on fifo_entry_o, which the FSM samples every cycle with no backpressure.

Parameters:
- DEPTH, 16, number of entry slots; power of two, at least 4.
- NR_PORTS, 2, number of commit ports written per cycle; 1 to 4.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- entry_i  in  NR_PORTS x fifo_entry_s  per-port entries; entry_i[k].valid qualifies port k
- flush_i  in  1  synchronous clear of all stored entries and the overflow flag
- fifo_entry_o  out  fifo_entry_s  head entry; .valid=1 only when an entry is popped this cycle
- empty_o  out  1  no stored entries
- full_o  out  1  usage equals DEPTH
- usage_o  out  $clog2(DEPTH)+1  number of stored entries
- overflow_o  out  1  sticky: at least one valid input entry was dropped

Behaviour:
- Reset (rst_i=1, async, any cycle including mid-burst):
  - read/write pointers and usage = 0, overflow_o = 0.
  - fifo_entry_o all-zero, empty_o = 1, full_o = 0.
  - Storage contents are don't-care.
- Pop:
  - Whenever usage > 0, the head slot is driven combinationally on fifo_entry_o with .valid=1, and it is popped at the next rising edge.
  - When empty, fifo_entry_o is all-zero, including .valid=0.
  - Exactly one pop per cycle, with no ready input.
- Push:
  - Valid ports are compacted in ascending port index; invalid ports leave no gaps.
  - Example: valid on ports {1,3} writes port 1 then port 3 into consecutive slots.
  - Entries are stored unmodified.
- Latency: an entry pushed at edge N can appear on fifo_entry_o no earlier than the cycle after edge N. There is no same-cycle bypass.
- Capacity accounting:
  - free = DEPTH - usage + pop, where pop = (usage>0). Same-cycle pop frees space for same-cycle push.
  - If nvalid <= free, all entries are accepted.
  - Otherwise the first free valid entries (port order) are accepted, the rest are dropped, and overflow_o is set at that edge.
- Pointers: modulo DEPTH with natural wrap. usage_o(next) = usage + accepted - pop; it never exceeds DEPTH and never goes below 0.
- full_o and empty_o are derived from the usage register, with no separate state.
- overflow_o stays 1 until flush_i or reset.
- flush_i:
  - At the edge it clears pointers, usage and overflow.
  - Inputs presented in the flush cycle are discarded.
  - The head entry shown in the flush cycle is still considered output, because the FSM samples it.
  - Reset has priority over flush_i.
- No X-propagation on fifo_entry_o when empty: all fields are forced to zero.

Decomposition:
- mure_pkg additions:
  - NR_COMMIT_PORTS (=2) and COMMIT_FIFO_DEPTH (=16), used as instantiation defaults.
  - The existing fifo_entry_s is reused unchanged.
- Sub-module commit_compactor: combinational; NR_PORTS entries in, compacted entry array plus count out (count width $clog2(NR_PORTS)+1).
- Top level holds storage, pointers, usage, overflow and the pop/push accounting.

Test Plan:
- Reset then idle: fifo_entry_o.valid=0, usage_o=0, empty_o=1. Assert rst_i mid-burst with usage_o=5 -> usage_o=0 and fifo_entry_o all-zero immediately, without waiting for a clock edge.
- Single push: port 0 pushes pc=0x1000 (itype=0, compressed=1) at edge N -> fifo_entry_o.valid=1, pc=0x1000 in cycle N+1 only; usage_o back to 0 after edge N+1.
- Dual push with gap compaction (NR_PORTS=4): valid on ports 1 (pc=0x20) and 3 (pc=0x24) -> outputs pc=0x20 then 0x24 on consecutive cycles; usage_o peaks at 2.
- Fill and wrap: push 2 per cycle for 20 cycles with DEPTH=16 -> usage_o grows by 1 per cycle (2 in, 1 out) until 16, full_o=1, then further excess entries are dropped and overflow_o=1. Stop pushing -> 16 entries drain in order across the pointer wrap.
- Same-cycle pop/push at full: usage=16, push 1 -> accepted, usage stays 16, overflow_o stays 0. Push 2 -> one dropped (port-1 entry), overflow_o=1.
- Flush: usage=7, overflow_o=1, push 2 in the flush cycle -> next cycle usage_o=0, overflow_o=0, empty_o=1. The flushed-cycle inputs never appear on fifo_entry_o.
